booth_mul_seq: RTL and testbench

Iterative radix-4 Booth multiplier sequencer for the FPU mantissa/integer multiply path. It accepts one pair of signed two's-complement operands through a valid/ready handshake. It retires one Booth digit per cycle from the multiplier, using the team's radix-4 Booth digit encoding (0, ±1, ±2) and a carry-propagate adder. It returns the exact 2·DWIDTH-bit product through a second valid/ready handshake. The block is single-issue: it holds one operation at a time and has no overlap.

---
 rtl/booth_mul_seq.sv | 180 ++++++++++++++++++
 tb/tb_booth_mul_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier, one digit per cycle.
//
// Single-issue sequencer: accepts a signed operand pair on the in_valid/in_ready
// handshake and returns the exact 2*DWIDTH-bit signed product on the
// out_valid/out_ready handshake.
//
// Optional feature macro: BOOTH_MUL_SEQ_EARLY_TERM_EN
//   When defined, the sequencer stops as soon as every remaining Booth digit is
//   known to be zero. This happens when the unconsumed multiplier bits, plus the
//   overlap bit, are all identical. The product is bit-identical either way.
//   When undefined, every operation takes DWIDTH/2 steps.

module booth_mul_seq #(
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     a,
    input  logic [DWIDTH-1:0]     b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DWIDTH-1:0]   product,
    output logic                  busy
);

    localparam int NSTEP = DWIDTH / 2;
    localparam int SW    = $clog2(NSTEP + 1);
    localparam int PW    = DWIDTH + 2;       // partial product width, holds +2^DWIDTH
    localparam int RW    = 2 * DWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [DWIDTH-1:0]   a_q;
    logic [DWIDTH-1:0]   b_q;        // multiplier, arithmetically shifted by 2 per step
    logic                bm1_q;      // overlap bit b[2i-1] for the current step
    logic [RW-1:0]       acc_q;
    logic [SW-1:0]       step_q;
    logic [RW-1:0]       product_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic                dig_one;
    logic                dig_two;
    logic                dig_neg;
    logic [PW-1:0]       a_ext;
    logic [PW-1:0]       mag;
    logic [PW-1:0]       pp;
    logic [RW-1:0]       pp_sext;
    logic [RW-1:0]       pp_shift;
    logic [RW-1:0]       acc_d;
    logic [DWIDTH-1:0]   b_d;
    logic                bm1_d;
    logic                last_fixed;
    logic                last_step;

    // Decode the current Booth digit from {b[2i+1], b[2i], b[2i-1]}
    always_comb begin
        dig_one = 1'b0;
        dig_two = 1'b0;
        dig_neg = 1'b0;
        case ({b_q[1], b_q[0], bm1_q})
            3'b001, 3'b010: dig_one = 1'b1;
            3'b011:         dig_two = 1'b1;
            3'b100: begin
                dig_two = 1'b1;
                dig_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                dig_one = 1'b1;
                dig_neg = 1'b1;
            end
            default: begin
                dig_one = 1'b0;
                dig_two = 1'b0;
                dig_neg = 1'b0;
            end
        endcase
    end

    // Partial product and carry-propagate accumulate at weight 4^step
    always_comb begin
        a_ext = {{2{a_q[DWIDTH-1]}}, a_q};
        if (dig_two) begin
            mag = a_ext << 1;
        end else if (dig_one) begin
            mag = a_ext;
        end else begin
            mag = '0;
        end
        // Negative digits: inverted magnitude with carry-in of one
        pp       = dig_neg ? (~mag + PW'(1)) : mag;
        pp_sext  = {{(RW - PW){pp[PW-1]}}, pp};
        pp_shift = pp_sext << {step_q, 1'b0};
        acc_d    = acc_q + pp_shift;
    end

    // Advance the multiplier window and decide whether this is the final step
    always_comb begin
        b_d        = {{2{b_q[DWIDTH-1]}}, b_q[DWIDTH-1:2]};
        bm1_d      = b_q[1];
        last_fixed = (step_q == SW'(NSTEP - 1));
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
        // After the shift, b_d holds b[DWIDTH-1:2k] sign-extended, and bm1_d is b[2k-1].
        // If all of them match, every later digit decodes as 0.
        last_step  = last_fixed || (b_d == {DWIDTH{bm1_d}});
`else
        last_step  = last_fixed;
`endif
    end

    // Sequencer FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            bm1_q       <= 1'b0;
            acc_q       <= '0;
            step_q      <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        bm1_q      <= 1'b0;
                        acc_q      <= '0;
                        step_q     <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_q  <= acc_d;
                    b_q    <= b_d;
                    bm1_q  <= bm1_d;
                    step_q <= step_q + SW'(1);
                    if (last_step) begin
                        product_q   <= acc_d;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: scoreboard bench for booth_mul_seq.
// The driver pushes the expected product and step count on each accept.
// An independent monitor pops an entry and compares it on every output transfer.
// Set BOOTH_MUL_SEQ_EARLY_TERM_EN to match the DUT build.

module tb_booth_mul_seq;

    localparam int W  = 32;
    localparam int NS = W / 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] product;

    always #5 clk = ~clk;

    booth_mul_seq #(.DWIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int bp_mode = 0;   // 0: out_ready=1, 1: random, 2: held low

    typedef struct {
        logic [2*W-1:0] p;
        int             steps;
        int             acc_cyc;
        string          name;
    } exp_t;

    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom % 3) != 0;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: plain 64-bit signed arithmetic
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] av, input logic [W-1:0] bv);
        longint sa;
        longint sbv;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        return sa * sbv;
    endfunction

    // Reference step count: smallest k>=1 with b[W-1:2k-1] all identical (early mode)
    function automatic int ref_steps(input logic [W-1:0] bv);
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
        for (int k = 1; k <= NS; k++) begin
            logic signed [W-1:0] t;
            t = $signed(bv) >>> (2 * k - 1);
            if (t == 0 || t == -1) return k;
        end
        return NS;
`else
        return NS;
`endif
    endfunction

    // Called at a negedge. Returns at the negedge after acceptance with in_valid still high.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] expv, input string nm);
        int  n;
        int  e;
        bit  rdy;
        bit  ok;
        exp_t it;
        a = av;
        b = bv;
        in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (n < 3000) begin
            rdy = in_ready;
            e   = cyc;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (ok) begin
            it.p = expv; it.steps = ref_steps(bv); it.acc_cyc = e; it.name = nm;
            sb.push_back(it);
        end else begin
            checks++;
            $display("FAIL %s accept: got no accept expected accept within 3000 cycles", nm);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(sb.size() == 0 && in_ready)) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                checks++;
                $display("FAIL %s idle_timeout: got busy expected idle within 5000 cycles", nm);
                sb.delete();
                break;
            end
        end
    endtask

    // Monitor: protocol invariants every cycle and scoreboard pop on each transfer
    logic           ov_prev = 1'b0;
    logic [2*W-1:0] p_prev  = '0;
    int             rise_cyc = 0;

    always @(negedge clk) begin
        exp_t it;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            chk("busy_vs_in_ready", 64'(busy), 64'(!in_ready));
            if (out_valid) chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
            if (out_valid && ov_prev) chk("product_hold", product, p_prev);
            if (out_valid && !ov_prev) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got %h expected no output", product);
                end else begin
                    it = sb.pop_front();
                    chk({it.name, " product"}, product, it.p);
                    chk({it.name, " latency"}, 64'(rise_cyc - it.acc_cyc), 64'(it.steps + 1));
                end
            end
            ov_prev = out_valid;
            p_prev  = product;
        end
    end

    initial begin
        int n;
        int r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset product", product, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed values
        bp_mode = 0;
        @(negedge clk);
        issue(32'd7, -32'sd3, 64'hFFFF_FFFF_FFFF_FFEB, "7x-3");
        in_valid = 1'b0;
        wait_idle("7x-3");
        issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minxmin");
        in_valid = 1'b0;
        wait_idle("minxmin");
        issue(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, "minxmax");
        in_valid = 1'b0;
        wait_idle("minxmax");

        // Backpressure hold: out_ready low 5 cycles, second in_valid ignored
        bp_mode = 2;
        @(negedge clk);
        @(negedge clk);
        issue(32'h0000_1357, 32'h8000_0001, ref_prod(32'h0000_1357, 32'h8000_0001), "hold");
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold out_valid_rise", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            a = 32'd5; b = 32'd5; in_valid = 1'b1;
            @(negedge clk);
            chk("hold out_valid", 64'(out_valid), 64'd1);
            chk("hold in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        bp_mode = 0;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold release out_valid", 64'(out_valid), 64'd0);
        chk("hold release in_ready", 64'(in_ready), 64'd1);
        chk("hold second op ignored", 64'(sb.size()), 64'd0);
        @(negedge clk);
        chk("hold idle stays", 64'(busy), 64'd0);

        // Reset mid-RUN discards the in-flight operation
        issue(32'h1234_5678, 32'h9ABC_DEF1, 64'd0, "rst_abort");
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort product", product, 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        issue(32'd3, 32'd5, 64'd15, "3x5");
        in_valid = 1'b0;
        wait_idle("3x5");

        // Back-to-back with in_valid held high
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "b2b_m1xm1");
        issue(32'd0, 32'd123, 64'd0, "b2b_0x123");
        in_valid = 1'b0;
        wait_idle("b2b");

        // Random operands with random backpressure
        bp_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            ra = $urandom;
            rb = $urandom;
            r  = $urandom % 10;
            case (r)
                0: ra = 32'h8000_0000;
                1: rb = 32'h8000_0000;
                2: rb = '0;
                3: rb = '1;
                4: rb = 32'($urandom % 64);
                5: rb = -32'($urandom % 64);
                6: rb = 32'h7FFF_FFFF;
                default: ;
            endcase
            issue(ra, rb, ref_prod(ra, rb), "rand");
            if ($urandom % 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        wait_idle("rand");
        bp_mode = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
